// File: rtl/gray_sync_decoder.sv
// Synchronizes an asynchronous Gray-coded word, decodes it to binary and tracks change direction and illegal jumps.
// Optional chg_count event counter is enabled with `define GRAY_SYNC_CHG_COUNT_EN.
module gray_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             chg,
    output logic             dir_up,
    output logic             step_err
`ifdef GRAY_SYNC_CHG_COUNT_EN
    ,
    output logic [15:0]      chg_count
`endif
);

    typedef enum logic [1:0] {
        S_INIT,
        S_TRACK,
        S_FAULT
    } state_t;

    // S_INIT waits until post-reset data has crossed the synchronizer before loading.
    localparam logic [2:0] INIT_WAIT = 3'(SYNC_STAGES);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sg;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             any_chg;
    logic             multi_chg;

    state_t           state_q,    state_d;
    logic [2:0]       init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0] sg_prev_q,  sg_prev_d;
    logic [WIDTH-1:0] bin_q,      bin_d;
    logic             chg_q,      chg_d;
    logic             dir_q,      dir_d;
    logic             err_q,      err_d;

    // NOTE: every synchronizer stage is reset as well, so no stale pre-reset value can leak into the decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sg = sync_q[SYNC_STAGES-1];

    always_comb begin
        logic acc;
        acc = 1'b0;
        b   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc  = acc ^ sg[i];
            b[i] = acc;
        end
    end

    // More than one set bit in diff means diff & (diff-1) is non-zero.
    assign diff      = sg ^ sg_prev_q;
    assign any_chg   = |diff;
    assign multi_chg = |(diff & (diff - WIDTH'(1)));

    // NOTE: every output of this block gets a default first, so no latch is inferred on any path.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        sg_prev_d  = sg_prev_q;
        bin_d      = bin_q;
        chg_d      = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;
        unique case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_WAIT) begin
                    bin_d     = b;
                    sg_prev_d = sg;
                    err_d     = 1'b0;
                    state_d   = S_TRACK;
                end else begin
                    init_cnt_d = init_cnt_q + 3'd1;
                end
            end
            S_TRACK, S_FAULT: begin
                if (any_chg) begin
                    bin_d     = b;
                    sg_prev_d = sg;
                    chg_d     = 1'b1;
                    if (!multi_chg) dir_d = (b == bin_q + WIDTH'(1));
                end
                // A new illegal jump outranks a simultaneous clear request.
                if (any_chg && multi_chg) begin
                    err_d   = 1'b1;
                    state_d = S_FAULT;
                end else if (state_q == S_FAULT && err_clr) begin
                    err_d   = 1'b0;
                    state_d = S_TRACK;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            sg_prev_q  <= '0;
            bin_q      <= '0;
            chg_q      <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sg_prev_q  <= sg_prev_d;
            bin_q      <= bin_d;
            chg_q      <= chg_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign bin_out  = bin_q;
    assign chg      = chg_q;
    assign dir_up   = dir_q;
    assign step_err = err_q;

`ifdef GRAY_SYNC_CHG_COUNT_EN
    logic [15:0] chg_count_q, chg_count_d;

    always_comb begin
        chg_count_d = chg_count_q;
        if (chg_q && chg_count_q != 16'hFFFF) chg_count_d = chg_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) chg_count_q <= '0;
        else        chg_count_q <= chg_count_d;
    end

    assign chg_count = chg_count_q;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder: table-driven Gray walks with a latency-aware scoreboard,
// plus hand-written error, clear and mid-stream reset sequences.
module tb_gray_sync_decoder;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] gray_in;
    logic             err_clr;
    logic [WIDTH-1:0] bin_out;
    logic             chg;
    logic             dir_up;
    logic             step_err;
`ifdef GRAY_SYNC_CHG_COUNT_EN
    logic [15:0]      chg_count;
`endif

    gray_sync_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gray_in (gray_in),
        .err_clr (err_clr),
        .bin_out (bin_out),
        .chg     (chg),
        .dir_up  (dir_up),
        .step_err(step_err)
`ifdef GRAY_SYNC_CHG_COUNT_EN
        ,
        .chg_count(chg_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] gray;
        logic [WIDTH-1:0] exp_bin;
        logic             exp_dir;
        logic             exp_err;
    } vec_t;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] exp_bin;
        logic             exp_dir;
        logic             exp_err;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] to_gray(input int v);
        logic [WIDTH-1:0] x;
        x = WIDTH'(v);
        return x ^ (x >> 1);
    endfunction

    task automatic add_vec(input int bin_val, input logic d, input logic e);
        vec_t v;
        v.gray    = to_gray(bin_val);
        v.exp_bin = WIDTH'(bin_val);
        v.exp_dir = d;
        v.exp_err = e;
        vecs.push_back(v);
    endtask

    // Drive a new Gray word; its decoded result is due SYNC_STAGES+1 edges after first being sampled.
    task automatic step(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] eb,
                        input logic ed, input logic ee, input int gap);
        sb_t s;
        @(negedge clk);
        gray_in   = g;
        s.due     = cyc + SYNC_STAGES + 1;
        s.exp_bin = eb;
        s.exp_dir = ed;
        s.exp_err = ee;
        sb.push_back(s);
        repeat (gap - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                check("sb_chg", 32'(chg), 32'd1);
                check("sb_bin", 32'(bin_out), 32'(sb[0].exp_bin));
                check("sb_dir", 32'(dir_up), 32'(sb[0].exp_dir));
                check("sb_err", 32'(step_err), 32'(sb[0].exp_err));
                void'(sb.pop_front());
            end else begin
                check("idle_chg", 32'(chg), 32'd0);
                if (sb.size() != 0 && sb[0].due < cyc) begin
                    check("sb_late", 32'(cyc), 32'(sb[0].due));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 1; i < 16; i++) add_vec(i, 1'b1, 1'b0);
        add_vec(0, 1'b1, 1'b0);
        add_vec(15, 1'b0, 1'b0);
        for (int i = 14; i >= 5; i--) add_vec(i, 1'b0, 1'b0);

        rst_n   = 1'b0;
        gray_in = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bin", 32'(bin_out), 32'd0);
        check("rst_chg", 32'(chg), 32'd0);
        check("rst_dir", 32'(dir_up), 32'd0);
        check("rst_err", 32'(step_err), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        check("hold0_bin", 32'(bin_out), 32'd0);
        check("hold0_dir", 32'(dir_up), 32'd0);
        check("hold0_err", 32'(step_err), 32'd0);

        foreach (vecs[i]) step(vecs[i].gray, vecs[i].exp_bin, vecs[i].exp_dir, vecs[i].exp_err, 10);

        step(4'b1100, 4'd8, 1'b0, 1'b1, 10);
        check("err_sticky", 32'(step_err), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(step_err), 32'd0);

        step(to_gray(7), 4'd7, 1'b0, 1'b0, 10);
        step(to_gray(6), 4'd6, 1'b0, 1'b0, 10);
        step(to_gray(5), 4'd5, 1'b0, 1'b0, 10);
        step(4'b1100, 4'd8, 1'b0, 1'b1, 10);
        step(to_gray(7), 4'd7, 1'b0, 1'b1, 10);
        step(to_gray(6), 4'd6, 1'b0, 1'b1, 10);
        step(to_gray(5), 4'd5, 1'b0, 1'b1, 10);

        step(4'b1100, 4'd8, 1'b0, 1'b1, 1);
        repeat (SYNC_STAGES) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("set_wins", 32'(step_err), 32'd1);
        repeat (5) @(negedge clk);
        check("set_wins_hold", 32'(step_err), 32'd1);

        step(to_gray(7), 4'd7, 1'b0, 1'b1, 10);
        step(to_gray(6), 4'd6, 1'b0, 1'b1, 10);
        check("pre_rst_bin", 32'(bin_out), 32'd6);

        @(negedge clk);
        gray_in = 4'b1111;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_bin", 32'(bin_out), 32'd0);
        check("mid_rst_chg", 32'(chg), 32'd0);
        check("mid_rst_dir", 32'(dir_up), 32'd0);
        check("mid_rst_err", 32'(step_err), 32'd0);
        repeat (6) @(negedge clk);
        check("init_load_bin", 32'(bin_out), 32'b1010);
        check("init_load_err", 32'(step_err), 32'd0);
        step(4'b1110, 4'd11, 1'b1, 1'b0, 10);

`ifdef GRAY_SYNC_CHG_COUNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("cnt_rst", 32'(chg_count), 32'd0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) step(4'b1111, 4'd10, 1'b0, 1'b0, 6);
            else            step(4'b1110, 4'd11, 1'b1, 1'b0, 6);
        end
        repeat (3) @(negedge clk);
        check("cnt_20", 32'(chg_count), 32'd20);
        @(negedge clk);
        dut.chg_count_q = 16'hFFFE;
        step(4'b1111, 4'd10, 1'b0, 1'b0, 6);
        step(4'b1110, 4'd11, 1'b1, 1'b0, 6);
        step(4'b1111, 4'd10, 1'b0, 1'b0, 6);
        repeat (3) @(negedge clk);
        check("cnt_sat", 32'(chg_count), 32'hFFFF);
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
